// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the register file's single write port among four writeback sources
// (e.g. ALU, load, link register, debug) with round-robin fairness. The
// winning requester's address and data are registered onto the write port
// together with a one-cycle grant pulse back to that requester.
//
// Ports:
//   clk         in   system clock, all state updates on the rising edge
//   reset_n     in   asynchronous active-low reset
//   req         in   [NREQ]         per-requester write request (level)
//   wr_addr_i   in   [NREQ*ADDR_W]  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wr_data_i   in   [NREQ*DATA_W]  packed data, requester i at [i*DATA_W +: DATA_W]
//   gnt         out  [NREQ]         one-hot grant, single-cycle pulse (registered)
//   rf_wr_en    out  register file write enable (registered)
//   rf_wr_addr  out  [ADDR_W] register file write address (registered)
//   rf_wr_data  out  [DATA_W] register file write data (registered)
//   busy        out  combinational OR of eligible requests (req & ~gnt)
//
// Build option:
//   RF_ZERO_FILTER_EN  when defined, a winning write addressed to the zero
//                      register (all-ones address, X31) still gets its grant
//                      and advances the pointer, but rf_wr_en is held low so
//                      the write never reaches the register file.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int NREQ   = 4,   // fixed at 4: the pointer is 2 bits wide
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   wr_addr_i,
  input  logic [NREQ*DATA_W-1:0]   wr_data_i,
  output logic [NREQ-1:0]          gnt,
  output logic                     rf_wr_en,
  output logic [ADDR_W-1:0]        rf_wr_addr,
  output logic [DATA_W-1:0]        rf_wr_data,
  output logic                     busy
);

  localparam int PTR_W = 2;
  // The zero register is the highest-numbered register (all-ones address).
  localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b1}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]   gnt_reg,        gnt_next;
  logic              rf_wr_en_reg,   rf_wr_en_next;
  logic [ADDR_W-1:0] rf_wr_addr_reg, rf_wr_addr_next;
  logic [DATA_W-1:0] rf_wr_data_reg, rf_wr_data_next;
  logic [PTR_W-1:0]  ptr_reg,        ptr_next;

  // ---------------------------------------------------------------------------
  // Unpack the per-requester address and data buses
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = wr_addr_i[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = wr_data_i[gi*DATA_W +: DATA_W];
  end

  // ---------------------------------------------------------------------------
  // Eligibility: a requester whose grant is high this cycle is still holding
  // its req (it only drops on the following edge), so it must be masked or it
  // would be granted twice for one write.
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] elig;

  assign elig = req & ~gnt_reg;
  assign busy = |elig;

  // ---------------------------------------------------------------------------
  // Round-robin search. The eligible vector is rotated so that position 0 is
  // the requester the pointer names; a fixed low-first priority encoder on
  // the rotated vector then finds the first eligible requester at or after
  // ptr, wrapping 3 -> 0 through the 2-bit index arithmetic.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] rot_idx [NREQ];
  logic [NREQ-1:0]  rot_elig;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rotate
    localparam logic [PTR_W-1:0] OFF = PTR_W'(gi);
    assign rot_idx[gi]  = ptr_reg + OFF;
    assign rot_elig[gi] = elig[rot_idx[gi]];
  end

  logic             win_found;
  logic [PTR_W-1:0] win_off;
  logic [PTR_W-1:0] winner;

  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    // Descending scan so the lowest rotated offset is the last to assign.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_elig[k]) begin
        win_found = 1'b1;
        win_off   = PTR_W'(k);
      end
    end
  end

  assign winner = ptr_reg + win_off;

  // One-hot decode of the winning index.
  logic [NREQ-1:0] win_onehot;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign win_onehot[gi] = (winner == PTR_W'(gi));
  end

  // ---------------------------------------------------------------------------
  // Winner's write-port payload and whether it may actually write
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_wr_en;

  assign win_addr = addr_arr[winner];
  assign win_data = data_arr[winner];

`ifdef RF_ZERO_FILTER_EN
  // Writes to the hard-wired zero register are accepted (granted) but
  // suppressed at the write enable.
  assign win_wr_en = (win_addr != ZERO_REG);
`else
  // Address 31 is written like any other; ZERO_REG is unused in this build.
  logic unused_zero_reg;
  assign unused_zero_reg = &ZERO_REG;
  assign win_wr_en       = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Idle cycle: no grant, no write; address/data and pointer hold.
    gnt_next        = '0;
    rf_wr_en_next   = 1'b0;
    rf_wr_addr_next = rf_wr_addr_reg;
    rf_wr_data_next = rf_wr_data_reg;
    ptr_next        = ptr_reg;

    if (win_found) begin
      gnt_next        = win_onehot;
      rf_wr_en_next   = win_wr_en;
      rf_wr_addr_next = win_addr;
      rf_wr_data_next = win_data;
      // The requester just served becomes lowest priority next time.
      ptr_next        = winner + PTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset clears a pending grant/write immediately; that write is
  // lost and requesters re-issue after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_reg        <= '0;
      rf_wr_en_reg   <= 1'b0;
      rf_wr_addr_reg <= '0;
      rf_wr_data_reg <= '0;
      ptr_reg        <= '0;
    end else begin
      gnt_reg        <= gnt_next;
      rf_wr_en_reg   <= rf_wr_en_next;
      rf_wr_addr_reg <= rf_wr_addr_next;
      rf_wr_data_reg <= rf_wr_data_next;
      ptr_reg        <= ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt        = gnt_reg;
  assign rf_wr_en   = rf_wr_en_reg;
  assign rf_wr_addr = rf_wr_addr_reg;
  assign rf_wr_data = rf_wr_data_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter. A behavioural model tracks
// the expected grant, write port and pointer from the arbitration rules; a
// compare process checks the DUT against it on every falling clock edge.
// Directed sequences with literal expectations are followed by a randomized
// phase of requesters obeying the req/gnt handshake.
// Inputs change 2 time units after the rising edge; outputs are compared on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

`ifdef RF_ZERO_FILTER_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ADDR_W-1:0] wr_addr_i = '0;
  logic [NREQ*DATA_W-1:0] wr_data_i = '0;
  logic [NREQ-1:0]        gnt;
  logic                   rf_wr_en;
  logic [ADDR_W-1:0]      rf_wr_addr;
  logic [DATA_W-1:0]      rf_wr_data;
  logic                   busy;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .NREQ  (NREQ),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .gnt       (gnt),
    .rf_wr_en  (rf_wr_en),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: who is next is the first requester with req high and
  // no grant in hand, counting upward from the pointer modulo 4.
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]   m_gnt  = '0;
  logic              m_en   = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_ptr  = 0;

  always @(posedge clk or negedge reset_n) begin : model
    logic [NREQ-1:0] elig;
    int win;
    int idx;
    if (!reset_n) begin
      m_gnt  <= '0;
      m_en   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_ptr  <= 0;
    end else begin
      elig = req & ~m_gnt;
      win  = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && elig[idx]) win = idx;
      end
      if (win >= 0) begin
        m_gnt  <= NREQ'(1 << win);
        m_en   <= ZF ? (wr_addr_i[win*ADDR_W +: ADDR_W] != 5'd31) : 1'b1;
        m_addr <= wr_addr_i[win*ADDR_W +: ADDR_W];
        m_data <= wr_data_i[win*DATA_W +: DATA_W];
        m_ptr  <= (win + 1) % NREQ;
      end else begin
        m_gnt <= '0;
        m_en  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, plus a starvation watch: a requester holding req
  // without a grant must be served within NREQ cycles.
  // ---------------------------------------------------------------------------
  int wait_cnt [NREQ];

  always @(negedge clk) begin
    if (chk_en) begin
      logic starved;
      check("gnt",        64'(gnt),        64'(m_gnt));
      check("rf_wr_en",   64'(rf_wr_en),   64'(m_en));
      check("rf_wr_addr", 64'(rf_wr_addr), 64'(m_addr));
      check("rf_wr_data", rf_wr_data,      m_data);
      check("busy",       64'(busy),       64'(|(req & ~m_gnt)));
      starved = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!reset_n || gnt[i] || !req[i]) wait_cnt[i] = 0;
        else wait_cnt[i] = wait_cnt[i] + 1;
        if (wait_cnt[i] > NREQ) starved = 1'b1;
      end
      check("fairness", 64'(starved), 64'(0));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_wr(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_addr_i[i*ADDR_W +: ADDR_W] = a;
    wr_data_i[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic new_req(input int i);
    logic [ADDR_W-1:0] a;
    a = ($urandom_range(0, 7) == 0) ? 5'd31 : ADDR_W'($urandom_range(0, 31));
    req[i] = 1'b1;
    set_wr(i, a, {$urandom, $urandom});
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  logic [NREQ-1:0] cur_g;
  logic [NREQ-1:0] prev_g;

  initial begin
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;

    // ---- Reset with all requests high --------------------------------------
    #1 reset_n = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_wr(i, ADDR_W'(i + 3), 64'h1111_0000 + 64'(i));
    #2;
    check("rst_gnt",  64'(gnt),        64'(0));
    check("rst_en",   64'(rf_wr_en),   64'(0));
    check("rst_addr", 64'(rf_wr_addr), 64'(0));
    check("rst_data", rf_wr_data,      64'(0));
    chk_en = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    req = 4'b0000;
    step();
    step();
    check("post_rst_gnt",  64'(gnt),        64'(0));
    check("post_rst_en",   64'(rf_wr_en),   64'(0));
    check("post_rst_addr", 64'(rf_wr_addr), 64'(0));
    check("post_rst_data", rf_wr_data,      64'(0));

    // ---- Single request from requester 2 -----------------------------------
    for (int i = 0; i < NREQ; i++) set_wr(i, '0, '0);
    set_wr(2, 5'd7, 64'hDEAD_BEEF);
    req = 4'b0100;
    step();
    check("single_gnt",  64'(gnt),        64'(4'b0100));
    check("single_en",   64'(rf_wr_en),   64'(1));
    check("single_addr", 64'(rf_wr_addr), 64'(7));
    check("single_data", rf_wr_data,      64'hDEAD_BEEF);
    step();
    req = 4'b0000;
    check("single_gnt_off",   64'(gnt),        64'(0));
    check("single_en_off",    64'(rf_wr_en),   64'(0));
    check("single_addr_hold", 64'(rf_wr_addr), 64'(7));
    check("single_data_hold", rf_wr_data,      64'hDEAD_BEEF);
    step();

    // ---- Round robin from reset --------------------------------------------
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_wr(i, ADDR_W'(10 + i), 64'hA000 + 64'(i));
    req = 4'b1111;
    prev_g = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      cur_g = gnt;
      check($sformatf("rr_gnt%0d", k), 64'(cur_g), 64'(1) << exp_order[k]);
      // A requester drops in the cycle after its grant, re-raises after that.
      for (int i = 0; i < NREQ; i++) req[i] = ~prev_g[i];
      prev_g = cur_g;
    end
    req = 4'b0000;
    step();
    step();

    // ---- Masking: requester 1 holds req for three cycles -------------------
    set_wr(1, 5'd3, 64'h0BAD_F00D);
    req = 4'b0010;
    step();
    check("mask_c1", 64'(gnt), 64'(4'b0010));
    step();
    check("mask_c2", 64'(gnt), 64'(4'b0000));
    step();
    check("mask_c3", 64'(gnt), 64'(4'b0010));
    req = 4'b0000;
    step();
    step();

    // ---- Asynchronous reset during a grant ---------------------------------
    req = 4'b0010;
    step();
    check("arst_pre_gnt", 64'(gnt),      64'(4'b0010));
    check("arst_pre_en",  64'(rf_wr_en), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("arst_gnt", 64'(gnt),      64'(0));
    check("arst_en",  64'(rf_wr_en), 64'(0));
    step();
    reset_n = 1'b1;
    set_wr(3, 5'd20, 64'h3333);
    req = 4'b1010;
    step();
    check("arst_ptr0_gnt", 64'(gnt), 64'(4'b0010));
    step();
    check("arst_next_gnt", 64'(gnt), 64'(4'b1000));
    req = 4'b1000;
    step();
    req = 4'b0000;
    step();

    // ---- Write to the zero register ----------------------------------------
    set_wr(0, 5'd31, 64'h5A5A_5A5A);
    req = 4'b0001;
    step();
    check("zf_gnt",  64'(gnt),        64'(4'b0001));
    check("zf_en",   64'(rf_wr_en),   ZF ? 64'(0) : 64'(1));
    check("zf_addr", 64'(rf_wr_addr), 64'(31));
    step();
    req = 4'b0000;
    step();

    // ---- Randomized requesters following the handshake ---------------------
    prev_g = '0;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (prev_g[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else new_req(i);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
      prev_g = gnt;
    end
    req = 4'b0000;
    step();
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
